// File: rtl/instr_fetch.sv
// Instruction fetch unit. It shares a single-ported word memory with the
// execute stage and holds one fetched instruction at a time for decode.
// Data accesses from execute always win the memory port. A fetch retries
// on every cycle that execute keeps the port busy.
// Flow: FETCH captures a word, HOLD presents it until decode consumes it,
// and HALT parks the unit after a HALT opcode until resume is pulsed.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        data_req,
    input  logic [15:0] data_addr,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc,
    input  logic        branch_taken,
    input  logic [11:0] branch_offset,
    output logic        halted,
    input  logic        resume
);

    localparam logic [3:0] OP_HALT = 4'h0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;

    logic        consume;
    logic        held_is_halt;

    // Branch target is relative to the word after the branch; the 12-bit
    // signed word offset is sign-extended and the sum wraps at 16 bits.
    function automatic logic [15:0] branch_target(
        input logic [15:0] base_pc,
        input logic [11:0] offset
    );
        logic signed [15:0] offset_ext;
        offset_ext = {{4{offset[11]}}, offset};
        return base_pc + 16'd1 + offset_ext;
    endfunction

    // Memory port steering: an execute-stage data access takes priority in every state.
    always_comb begin
        mem_addr = fetch_pc_q;
        if (data_req) begin
            mem_addr = data_addr;
        end
    end

    // Decode handshake and opcode classification of the held word.
    always_comb begin
        consume      = (state_q == ST_HOLD) && instr_valid_q && instr_ready;
        held_is_halt = (instr_q[15:12] == OP_HALT);
    end

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;

        case (state_q)
            ST_FETCH: begin
                // A busy memory port leaves everything untouched so the
                // same address is fetched again next cycle.
                if (!data_req) begin
                    instr_d       = mem_rdata;
                    pc_d          = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 16'd1;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // Redirect and halt decisions are made only when decode
                // actually takes the word; otherwise the word is frozen.
                if (consume) begin
                    instr_valid_d = 1'b0;
                    if (held_is_halt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else if (branch_taken) begin
                        fetch_pc_d = branch_target(pc_q, branch_offset);
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HALT: begin
                // fetch_pc already points past the HALT word.
                if (resume) begin
                    halted_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end

            default: begin
                state_d       = ST_FETCH;
                instr_valid_d = 1'b0;
                halted_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any held instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // Registered outputs.
    always_comb begin
        instr       = instr_q;
        instr_valid = instr_valid_q;
        pc          = pc_q;
        halted      = halted_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural word memory feeds the DUT. A
// scoreboard queue holds the expected pc/instr of each fetched word.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        data_req;
    logic [15:0] data_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc;
    logic        branch_taken;
    logic [11:0] branch_offset;
    logic        halted;
    logic        resume;

    logic [15:0] mem [0:65535];

    logic [15:0] exp_pc_q[$];
    logic [15:0] exp_instr_q[$];
    logic [15:0] last_pc;
    logic [15:0] last_instr;

    int n_checks;
    int n_fail;

    instr_fetch #(.RESET_PC(16'h0100)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .data_req      (data_req),
        .data_addr     (data_addr),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .halted        (halted),
        .resume        (resume)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_expect(input logic [15:0] a);
        exp_pc_q.push_back(a);
        exp_instr_q.push_back(mem[a]);
    endfunction

    function automatic void pop_expect();
        if (exp_pc_q.size() != 0) begin
            last_pc    = exp_pc_q.pop_front();
            last_instr = exp_instr_q.pop_front();
        end else begin
            last_pc    = 16'hxxxx;
            last_instr = 16'hxxxx;
        end
    endfunction

    // Waits (bounded) for a valid word; decode is idle while waiting.
    task automatic wait_valid(input int limit, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < limit) begin
            @(negedge clk);
            cycles++;
            instr_ready  = 1'b0;
            branch_taken = 1'b0;
            if (instr_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // Consumes the held word at the coming edge and predicts the next fetch.
    task automatic do_consume(input bit br, input logic [11:0] off);
        logic [15:0] nxt;
        instr_ready   = 1'b1;
        branch_taken  = br;
        branch_offset = off;
        if (last_instr[15:12] == 4'h0 || !br) nxt = last_pc + 16'd1;
        else nxt = last_pc + 16'd1 + {{4{off[11]}}, off};
        push_expect(nxt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL reset_pc: got %h expected 0100", pc); end
        n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0100", mem_addr); end
        push_expect(16'h0100);
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        bit ok;
        int cyc;
        for (int k = 0; k < 5; k++) begin
            wait_valid(8, ok, cyc);
            pop_expect();
            n_checks++; if (!ok) begin n_fail++; $display("FAIL straight_timeout: no valid word at step %0d", k); end
            n_checks++; if (cyc !== ((k == 0) ? 1 : 2)) begin n_fail++; $display("FAIL straight_spacing: got %0d cycles expected %0d", cyc, (k == 0) ? 1 : 2); end
            n_checks++; if (pc !== last_pc) begin n_fail++; $display("FAIL straight_pc: got %h expected %h", pc, last_pc); end
            n_checks++; if (instr !== last_instr) begin n_fail++; $display("FAIL straight_instr: got %h expected %h", instr, last_instr); end
            do_consume(1'b0, 12'h000);
        end
    endtask

    task automatic test_branches();
        bit ok;
        int cyc;
        logic [11:0] offs [0:5];
        bit          brs  [0:5];
        offs = '{12'd13, 12'hFFC, 12'hFFC, 12'hEF2, 12'hFFF, 12'h000};
        brs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        // pcs visited: 105 -> 113 -> 110 -> 10D -> 0000 -> 0000 -> 0001
        for (int k = 0; k < 6; k++) begin
            wait_valid(8, ok, cyc);
            pop_expect();
            n_checks++; if (!ok) begin n_fail++; $display("FAIL branch_timeout: no valid word at step %0d", k); end
            n_checks++; if (pc !== last_pc) begin n_fail++; $display("FAIL branch_pc: got %h expected %h", pc, last_pc); end
            n_checks++; if (instr !== last_instr) begin n_fail++; $display("FAIL branch_instr: got %h expected %h", instr, last_instr); end
            do_consume(brs[k], offs[k]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        wait_valid(8, ok, cyc);
        pop_expect();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: no word before stall"); end
        n_checks++; if (pc !== last_pc) begin n_fail++; $display("FAIL stall_pre_pc: got %h expected %h", pc, last_pc); end
        do_consume(1'b0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_ready  = 1'b0;
            branch_taken = 1'b0;
            data_req     = 1'b1;
            data_addr    = 16'h0002;
            #1;
            n_checks++; if (mem_addr !== 16'h0002) begin n_fail++; $display("FAIL stall_mem_addr: got %h expected 0002", mem_addr); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid: got %b expected 0", instr_valid); end
        end
        @(negedge clk);
        data_req = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid: got %b expected 0", instr_valid); end
        n_checks++; if (mem_addr !== exp_pc_q[0]) begin n_fail++; $display("FAIL stall_fetch_addr: got %h expected %h", mem_addr, exp_pc_q[0]); end
        wait_valid(8, ok, cyc);
        pop_expect();
        n_checks++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL stall_resume: ok=%b cycles=%0d expected 1", ok, cyc); end
        n_checks++; if (pc !== last_pc) begin n_fail++; $display("FAIL stall_post_pc: got %h expected %h", pc, last_pc); end
        n_checks++; if (instr !== last_instr) begin n_fail++; $display("FAIL stall_post_instr: got %h expected %h", instr, last_instr); end
    endtask

    // Word is already held; decode stalls while noise hits branch/data inputs.
    task automatic test_backpressure();
        logic [15:0] da;
        for (int i = 0; i < 4; i++) begin
            da            = 16'($urandom);
            instr_ready   = 1'b0;
            branch_taken  = 1'b1;
            branch_offset = 12'($urandom);
            data_req      = 1'b1;
            data_addr     = da;
            #1;
            n_checks++; if (mem_addr !== da) begin n_fail++; $display("FAIL hold_mem_addr: got %h expected %h", mem_addr, da); end
            @(negedge clk);
            n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", instr_valid); end
            n_checks++; if (pc !== last_pc) begin n_fail++; $display("FAIL hold_pc: got %h expected %h", pc, last_pc); end
            n_checks++; if (instr !== last_instr) begin n_fail++; $display("FAIL hold_instr: got %h expected %h", instr, last_instr); end
        end
        data_req = 1'b0;
        do_consume(1'b1, 12'h10F);
    endtask

    task automatic test_halt_resume();
        bit ok;
        int cyc;
        wait_valid(8, ok, cyc);
        pop_expect();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL halt_timeout: no HALT word"); end
        n_checks++; if (pc !== 16'h0112 || instr !== 16'h0000) begin n_fail++; $display("FAIL halt_word: got %h@%h expected 0000@0112", instr, pc); end
        do_consume(1'b1, 12'h055);
        @(negedge clk);
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", halted); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b expected 0", instr_valid); end
            n_checks++; if (mem_addr !== exp_pc_q[0]) begin n_fail++; $display("FAIL halt_mem_addr: got %h expected %h", mem_addr, exp_pc_q[0]); end
            @(negedge clk);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_halted: got %b expected 0", halted); end
        wait_valid(8, ok, cyc);
        pop_expect();
        n_checks++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL resume_fetch: ok=%b cycles=%0d expected 1", ok, cyc); end
        n_checks++; if (pc !== 16'h0113 || pc !== last_pc) begin n_fail++; $display("FAIL resume_pc: got %h expected %h", pc, last_pc); end
        n_checks++; if (instr !== last_instr) begin n_fail++; $display("FAIL resume_instr: got %h expected %h", instr, last_instr); end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        int cyc;
        instr_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", instr_valid); end
        n_checks++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL midrst_pc: got %h expected 0100", pc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL midrst_halted: got %b expected 0", halted); end
        rst = 1'b0;
        exp_pc_q.delete();
        exp_instr_q.delete();
        push_expect(16'h0100);
        wait_valid(8, ok, cyc);
        pop_expect();
        n_checks++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL midrst_first_fetch: ok=%b cycles=%0d expected 1", ok, cyc); end
        n_checks++; if (pc !== last_pc) begin n_fail++; $display("FAIL midrst_post_pc: got %h expected %h", pc, last_pc); end
        n_checks++; if (instr !== 16'h8200) begin n_fail++; $display("FAIL midrst_post_instr: got %h expected 8200", instr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int a = 0; a < 65536; a++) mem[a] = {4'h1, 12'(a)};
        mem[16'h0100] = 16'h8200;
        mem[16'h0101] = 16'h6002;
        mem[16'h0105] = 16'hB00D;
        mem[16'h0112] = 16'h0000;
        rst = 1'b1;
        data_req = 1'b0;
        data_addr = 16'h0000;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_offset = 12'h000;
        resume = 1'b0;
        last_pc = 16'h0000;
        last_instr = 16'h0000;

        test_reset();
        test_straight_line();
        test_branches();
        test_stall();
        test_backpressure();
        test_halt_resume();
        test_reset_mid_hold();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0100, meaning the first instruction address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port mem_addr  output  16  address to the shared word memory (combinational read, same-cycle data).
REQ-005 SHALL have port mem_rdata  input  16  read data returned by the memory for mem_addr in the same cycle.
REQ-006 SHALL have port data_req  input  1  execute stage claims the memory port this cycle.
REQ-007 SHALL have port data_addr  input  16  execute-stage load/store address.
REQ-008 SHALL have port instr  output  16  held instruction word, opcode in [15:12].
REQ-009 SHALL have port instr_valid  output  1  instr is valid for decode.
REQ-010 SHALL have port instr_ready  input  1  decode consumes instr this cycle.
REQ-011 SHALL have port pc  output  16  address of the held instr.
REQ-012 SHALL have port branch_taken  input  1  redirect; sampled only on the consume cycle.
REQ-013 SHALL have port branch_offset  input  12  signed word offset of the branch.
REQ-014 SHALL have port halted  output  1  HALT opcode (4'h0) consumed; fetching stopped.
REQ-015 SHALL have port resume  input  1  leave halt and resume fetching.

Function
REQ-016 SHALL keep internal fetch_pc (16 b) and a 3-state FSM: FETCH, HOLD, HALT.
REQ-017 mem_addr SHALL be data_addr when data_req=1, else fetch_pc, in every state (data access has priority).
REQ-018 FETCH, data_req=0: on the edge, instr<=mem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^16), instr_valid<=1, go HOLD.
REQ-019 FETCH, data_req=1: no state change; fetch retried next cycle (stall).
REQ-020 Fetch latency SHALL be one cycle: instr_valid rises the cycle after a FETCH cycle with data_req=0; peak throughput one instruction per two cycles.
REQ-021 HOLD: instr, pc, instr_valid=1 SHALL stay stable until the consume cycle (instr_valid & instr_ready).
REQ-022 On consume with instr[15:12]=4'h0: instr_valid<=0, halted<=1, go HALT; branch_taken ignored.
REQ-023 On consume with branch_taken=1 (non-HALT): fetch_pc<=pc+1+sext(branch_offset), wrapping mod 2^16; go FETCH, instr_valid<=0.
REQ-024 On consume otherwise: fetch_pc unchanged (already pc+1); go FETCH, instr_valid<=0.
REQ-025 branch_taken SHALL be ignored in any cycle that is not a consume cycle.
REQ-026 HALT: instr_valid=0, halted=1, no fetch; on resume=1 halted<=0, go FETCH at fetch_pc (address after the HALT word).
REQ-027 data_req in HOLD or HALT SHALL only steer mem_addr, with no effect on FSM or registers.

Reset
REQ-028 With rst=1 at an edge: state<=FETCH, fetch_pc<=RESET_PC, pc<=RESET_PC, instr<=16'h0000, instr_valid<=0, halted<=0.
REQ-029 rst SHALL override every other input, including mid-HOLD, mid-stall and HALT; a held instruction is discarded.
REQ-030 First fetch SHALL occur in the first cycle after rst deasserts (address RESET_PC).

Verification
REQ-031 Straight-line: memory holds the standard program, instr_ready=1 -> instr 16'h8200 @pc 0x100, then 16'h6002 @0x101, each valid for 1 cycle, 2 cycles apart.
REQ-032 Forward branch: consume 16'hB00D @pc 0x105 with branch_taken=1, offset 12'd13 -> next instr from pc 0x113.
REQ-033 Backward branch: consume @pc 0x110, offset 12'hFFC, branch_taken=1 -> next pc 0x10D; offset 12'hFFF at pc 0x0000 -> next pc 0x0000 (wrap check).
REQ-034 Stall/backpressure: data_req=1 for 3 cycles in FETCH with data_addr 0x0002 -> mem_addr=0x0002, instr_valid stays 0, then fetch resumes; instr_ready=0 for 4 cycles in HOLD -> instr/pc unchanged.
REQ-035 Halt/resume: consume 16'h0000 @pc 0x112 -> halted=1, instr_valid=0; resume pulse -> fetch at 0x113, halted=0.
REQ-036 Reset mid-operation: rst in HOLD with instr_valid=1 -> next cycle instr_valid=0, pc=0x0100, first fetch at 0x0100 after release.
